// File: rtl/mux4_pkg.sv
// Shared constants for the mux_4 block: select encodings and default data width.
package mux4_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int MUX4_DEFAULT_N = 8;

endpackage

// File: rtl/mux_4_if.sv
// Bus bundle for mux_4: four data words, select/enable, and the combinational and registered results.
// Optional out_par signal exists only when MUX4_PARITY_EN is defined.
interface mux_4_if
  import mux4_pkg::*;
#(
  parameter int N = MUX4_DEFAULT_N
);

  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_c;
  logic [N-1:0] in_d;
  logic [1:0]   sel;
  logic         en;
  logic [N-1:0] out;
  logic [N-1:0] out_q;
  logic [1:0]   sel_q;
  logic         valid_q;
  logic         sel_change;
`ifdef MUX4_PARITY_EN
  logic         out_par;
`endif

`ifdef MUX4_PARITY_EN
  modport master (
    output in_a, in_b, in_c, in_d, sel, en,
    input  out, out_q, sel_q, valid_q, sel_change, out_par
  );

  modport slave (
    input  in_a, in_b, in_c, in_d, sel, en,
    output out, out_q, sel_q, valid_q, sel_change, out_par
  );
`else
  modport master (
    output in_a, in_b, in_c, in_d, sel, en,
    input  out, out_q, sel_q, valid_q, sel_change
  );

  modport slave (
    input  in_a, in_b, in_c, in_d, sel, en,
    output out, out_q, sel_q, valid_q, sel_change
  );
`endif

endinterface

// File: rtl/mux4_capture.sv
// Registered capture stage for mux_4: latches the selected word, its select, a valid flag and a select-change pulse.
// MUX4_PARITY_EN adds a registered even-parity bit of the captured word.
module mux4_capture
  import mux4_pkg::*;
#(
  parameter int N = MUX4_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   sel,
  input  logic [N-1:0] d,
  output logic [N-1:0] out_q,
  output logic [1:0]   sel_q,
  output logic         valid_q,
`ifdef MUX4_PARITY_EN
  output logic         out_par,
`endif
  output logic         sel_change
);

`ifdef MUX4_PARITY_EN
  function automatic logic even_parity(input logic [N-1:0] word);
    return ^word;
  endfunction
`endif

  // Capture on enable; the change pulse compares against the previous capture only once one exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      sel_q      <= SEL_A;
      valid_q    <= 1'b0;
      sel_change <= 1'b0;
`ifdef MUX4_PARITY_EN
      out_par    <= 1'b0;
`endif
    end else if (en) begin
      out_q      <= d;
      sel_q      <= sel;
      valid_q    <= 1'b1;
      sel_change <= valid_q && (sel != sel_q);
`ifdef MUX4_PARITY_EN
      out_par    <= even_parity(d);
`endif
    end else begin
      sel_change <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_4.sv
// Parameterised 4:1 multiplexer: combinational select onto bus.out plus a registered capture stage.
// Define MUX4_PARITY_EN to add the registered out_par parity output.
module mux_4
  import mux4_pkg::*;
#(
  parameter int N = MUX4_DEFAULT_N
) (
  input  logic clk,
  input  logic rst_n,
  mux_4_if.slave bus
);

  logic [N-1:0] words [4];
  logic [N-1:0] sel_word;

  // Every 2-bit select code maps to a source, so indexing needs no fallback.
  assign words[SEL_A] = bus.in_a;
  assign words[SEL_B] = bus.in_b;
  assign words[SEL_C] = bus.in_c;
  assign words[SEL_D] = bus.in_d;
  assign sel_word     = words[bus.sel];
  assign bus.out      = sel_word;

  mux4_capture #(
    .N (N)
  ) u_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (bus.en),
    .sel        (bus.sel),
    .d          (sel_word),
    .out_q      (bus.out_q),
    .sel_q      (bus.sel_q),
    .valid_q    (bus.valid_q),
`ifdef MUX4_PARITY_EN
    .out_par    (bus.out_par),
`endif
    .sel_change (bus.sel_change)
  );

endmodule

// File: tb/tb_mux_4.sv
// Self-checking bench for mux_4: table-driven vectors plus hand-written reset sequences.
module tb_mux_4;
  import mux4_pkg::*;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux_4_if #(.N(N)) bus ();

  mux_4 #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   sel;
    logic         en;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
    logic [N-1:0] exp_out;
    logic [N-1:0] exp_out_q;
    logic [1:0]   exp_sel_q;
    logic         exp_valid;
    logic         exp_chg;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_a = v.a;
    bus.in_b = v.b;
    bus.in_c = v.c;
    bus.in_d = v.d;
    bus.sel  = v.sel;
    bus.en   = v.en;
  endtask

  task automatic check_regs(input string tag, input logic [N-1:0] q, input logic [1:0] sq,
                            input logic v, input logic chg);
    check({tag, ".out_q"}, 32'(bus.out_q), 32'(q));
    check({tag, ".sel_q"}, 32'(bus.sel_q), 32'(sq));
    check({tag, ".valid_q"}, 32'(bus.valid_q), 32'(v));
    check({tag, ".sel_change"}, 32'(bus.sel_change), 32'(chg));
`ifdef MUX4_PARITY_EN
    check({tag, ".out_par"}, 32'(bus.out_par), 32'(^q));
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //             sel    en    a      b      c      d      out    out_q  sel_q  v     chg
    vecs[0]  = '{2'd0, 1'b0, 8'hAA, 8'h00, 8'hA0, 8'h0A, 8'hAA, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{2'd1, 1'b0, 8'hAA, 8'h00, 8'hA0, 8'h0A, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{2'd2, 1'b0, 8'hAA, 8'h00, 8'hA0, 8'h0A, 8'hA0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{2'd3, 1'b0, 8'hAA, 8'h00, 8'hA0, 8'h0A, 8'h0A, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{2'd2, 1'b1, 8'hAA, 8'h00, 8'hA0, 8'h0A, 8'hA0, 8'hA0, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{2'd3, 1'b1, 8'hAA, 8'h00, 8'hA0, 8'h0A, 8'h0A, 8'h0A, 2'd3, 1'b1, 1'b1};
    vecs[6]  = '{2'd3, 1'b0, 8'hAA, 8'h00, 8'hA0, 8'h0A, 8'h0A, 8'h0A, 2'd3, 1'b1, 1'b0};
    vecs[7]  = '{2'd0, 1'b0, 8'hAA, 8'h00, 8'hA0, 8'hFF, 8'hAA, 8'h0A, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{2'd0, 1'b1, 8'hAA, 8'h00, 8'hA0, 8'hFF, 8'hAA, 8'hAA, 2'd0, 1'b1, 1'b1};
    vecs[9]  = '{2'd1, 1'b1, 8'hAA, 8'h01, 8'hA0, 8'hFF, 8'h01, 8'h01, 2'd1, 1'b1, 1'b1};
    vecs[10] = '{2'd1, 1'b1, 8'hAA, 8'h55, 8'hA0, 8'hFF, 8'h55, 8'h55, 2'd1, 1'b1, 1'b0};
    vecs[11] = '{2'd2, 1'b0, 8'hAA, 8'h55, 8'h3C, 8'hFF, 8'h3C, 8'h55, 2'd1, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(vecs[0]);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    check_regs("reset_en_high", 8'h00, 2'd0, 1'b0, 1'b0);
    check("reset_comb_out", 32'(bus.out), 32'(8'hAA));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d.out", i), 32'(bus.out), 32'(vecs[i].exp_out));
      @(posedge clk);
      #1;
      check_regs($sformatf("v%0d", i), vecs[i].exp_out_q, vecs[i].exp_sel_q,
                 vecs[i].exp_valid, vecs[i].exp_chg);
    end

    // Capture 0x0A, then drop reset between edges.
    bus.in_d = 8'h0A;
    bus.sel  = SEL_D;
    bus.en   = 1'b1;
    @(posedge clk);
    #1;
    check_regs("pre_reset", 8'h0A, 2'd3, 1'b1, 1'b1);
    bus.en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("async_reset", 8'h00, 2'd0, 1'b0, 1'b0);
    check("async_reset.out", 32'(bus.out), 32'(8'h0A));
    bus.sel = SEL_A;
    #1;
    check("reset_comb_follow", 32'(bus.out), 32'(8'hAA));

    // Release between edges; first edge after release captures, no change pulse.
    @(negedge clk);
    rst_n   = 1'b1;
    bus.sel = SEL_C;
    bus.en  = 1'b1;
    @(posedge clk);
    #1;
    check_regs("first_after_reset", 8'h3C, 2'd2, 1'b1, 1'b0);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check_regs("hold_after_reset", 8'h3C, 2'd2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_4.md
# mux_4

Parameterised 4:1 data multiplexer with a combinational output and a registered capture stage. One of four N-bit inputs is selected by a 2-bit select and driven straight to `out`. The same value can be captured into an output register, with a valid flag and a select-change pulse. Used wherever datapath sources are steered onto a shared bus, such as the ALU operand and register-file write-back paths.

## Interface
- `N`, default 8: data width of every input and output word.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. This is the block's one clock and its only reset.
- `in_a`  in  N  data input, selected when `sel`=0.
- `in_b`  in  N  data input, selected when `sel`=1.
- `in_c`  in  N  data input, selected when `sel`=2.
- `in_d`  in  N  data input, selected when `sel`=3.
- `sel`  in  2  source select.
- `en`  in  1  capture enable for the registered stage.
- `out`  out  N  combinational selected word.
- `out_q`  out  N  registered selected word.
- `sel_q`  out  2  select value at last capture.
- `valid_q`  out  1  high once at least one capture has occurred since reset.
- `sel_change`  out  1  one-cycle pulse: the last capture used a different `sel` than the previous capture.

## Operation
- `out` = `in_a`/`in_b`/`in_c`/`in_d` for `sel` = 0/1/2/3.
- All four codes are defined, so there is no default or X branch.
- `out` is independent of `clk`, `rst_n` and `en`.
- Capture happens on a rising `clk` edge with `en`=1:
  - `out_q` ← `out`
  - `sel_q` ← `sel`
  - `valid_q` ← 1
  - `sel_change` ← (`valid_q` && `sel` != `sel_q`)
- Rising `clk` edge with `en`=0:
  - `out_q`, `sel_q` and `valid_q` hold.
  - `sel_change` ← 0.
- The first capture after reset never asserts `sel_change`.
- Recapturing the same `sel` with changed data updates `out_q` without asserting `sel_change`.
- Reset (`rst_n`=0) immediately forces:
  - `out_q`=0, `sel_q`=0, `valid_q`=0, `sel_change`=0, and `out_par`=0 if present.
  - Reset overrides `en`.

## Timing
- `out`: zero-cycle combinational path from `in_*` and `sel`.
- `out_q`/`sel_q`/`valid_q`: one cycle latency from inputs sampled at the capture edge.
- `sel_change`: asserted exactly one cycle, the cycle after the capture edge. A capture with a new `sel` on every cycle keeps it asserted back-to-back.
- Reset assertion mid-operation clears the registered outputs without waiting for a clock edge.
- Reset deassertion is synchronised externally. The first rising edge after release may capture.

## Configuration
- Macro `MUX4_PARITY_EN`.
- When defined:
  - Adds output `out_par` (1 bit).
  - `out_par` is the even parity (XOR reduction) of the value captured into `out_q`.
  - It is registered alongside `out_q`, updates only on capture, and resets to 0.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `mux4_pkg` holds:
  - Select encoding constants `SEL_A`=0, `SEL_B`=1, `SEL_C`=2, `SEL_D`=3 (2-bit).
  - Default width constant `MUX4_DEFAULT_N`=8.
- One sub-module is natural: `mux4_capture`. It holds the registered stage (`out_q`, `sel_q`, `valid_q`, `sel_change`, optional parity), fed by the top-level combinational select.

## Test plan
- Combinational select: `N`=8, `in_a`=0xAA, `in_b`=0x00, `in_c`=0xA0, `in_d`=0x0A, `en`=0.
  - Step `sel` 0→1→2→3.
  - `out` = 0xAA, 0x00, 0xA0, 0x0A with no clock required.
  - `out_q` stays 0 and `valid_q` stays 0.
- Capture: same inputs, `sel`=2, `en`=1 for one edge.
  - Next cycle: `out_q`=0xA0, `sel_q`=2, `valid_q`=1, `sel_change`=0 (first capture).
- Select change: after the previous case, `sel`=3, `en`=1 for one edge.
  - Result: `out_q`=0x0A, `sel_change`=1 for one cycle, then 0 with `en`=0.
- Hold: `en`=0, change `in_d` to 0xFF and `sel` to 0.
  - `out` follows immediately (0xAA).
  - `out_q` holds 0x0A.
- Async reset: assert `rst_n`=0 between clock edges with `out_q`=0x0A.
  - `out_q`=0, `sel_q`=0, `valid_q`=0 before the next edge.
  - `out` still reflects the inputs.
- Parity (`MUX4_PARITY_EN` defined): capture `in_a`=0xAA → `out_par`=0; capture `in_b`=0x01 with `sel`=1 → `out_par`=1.
